// File: rtl/vc_credit_tracker.sv
// Upstream credit receiver: queues delayed credit words, releases them in order when due,
// and keeps per-VC credit counters. Optional error detection under VC_CREDIT_CHECK_EN.
module vc_credit_tracker #(
    parameter int NUM_VCS   = 4,
    parameter int BUF_DEPTH = 8,
    parameter int CRQ_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [21:0]                  cr_in,
    input  logic [15:0]                  in_cycle,
    input  logic                         req_valid,
    input  logic [4:0]                   req_vc,
    output logic                         grant,
    output logic [NUM_VCS-1:0]           avail,
    output logic [$clog2(CRQ_DEPTH):0]   pend_count,
    output logic                         err
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = $clog2(CRQ_DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BUF_DEPTH);
    localparam logic [PW:0]   FULL_OCC = (PW + 1)'(CRQ_DEPTH);

    logic [CW-1:0] count     [NUM_VCS];
    logic [CW-1:0] count_nxt [NUM_VCS];
    logic [20:0]   mem       [CRQ_DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   occ;
    logic [4:0]    head_vc;
    logic [15:0]   head_cyc;
    logic [15:0]   age;
    logic          full, push, pop, vc_ok;

    assign {head_vc, head_cyc} = mem[head];
    // Wrap-safe due test: the head is due once in_cycle is at or past its release cycle.
    assign age   = in_cycle - head_cyc;
    assign pop   = (occ != '0) && !age[15];
    assign full  = (occ == FULL_OCC);
    assign push  = cr_in[21] && !full;
    assign vc_ok = ({1'b0, head_vc} < 6'(NUM_VCS));

    assign pend_count = occ;

    always_comb begin
        grant = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (req_valid && (req_vc == 5'(v)) && (count[v] != '0)) grant = 1'b1;
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            count_nxt[v] = count[v];
            avail[v]     = (count[v] != '0);
            if (pop && (head_vc == 5'(v)) && !(grant && (req_vc == 5'(v)))) begin
                if (count[v] != CNT_MAX) count_nxt[v] = count[v] + 1'b1;
            end else if (grant && (req_vc == 5'(v)) && !(pop && (head_vc == 5'(v)))) begin
                count_nxt[v] = count[v] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VCS; v++) count[v] <= CNT_MAX;
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            count <= count_nxt;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Queue storage carries data only; validity is tracked by occ.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= cr_in[20:0];
    end

`ifdef VC_CREDIT_CHECK_EN
    logic ovf, bad_vc, drop;

    always_comb begin
        ovf = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (pop && (head_vc == 5'(v)) && (count[v] == CNT_MAX) &&
                !(grant && (req_vc == 5'(v)))) ovf = 1'b1;
        end
    end

    assign bad_vc = pop && !vc_ok;
    assign drop   = cr_in[21] && full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    err <= 1'b0;
        else if (ovf || bad_vc || drop) err <= 1'b1;
    end
`else
    assign err = 1'b0;
    logic unused_vc_ok;
    assign unused_vc_ok = vc_ok;
`endif

endmodule

// File: tb/tb_vc_credit_tracker.sv
// Bench for vc_credit_tracker: vector table plus hand sequences; post-edge
// expectations travel through a scoreboard queue.
module tb_vc_credit_tracker;
`ifdef VC_CREDIT_CHECK_EN
    localparam bit E = 1'b1;
`else
    localparam bit E = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [21:0] cr_in;
    logic [15:0] in_cycle;
    logic        req_valid;
    logic [4:0]  req_vc;
    logic        grant;
    logic [3:0]  avail;
    logic [4:0]  pend_count;
    logic        err;

    int errors = 0;
    int checks = 0;

    vc_credit_tracker #(.NUM_VCS(4), .BUF_DEPTH(8), .CRQ_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .cr_in(cr_in), .in_cycle(in_cycle),
        .req_valid(req_valid), .req_vc(req_vc), .grant(grant),
        .avail(avail), .pend_count(pend_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [3:0] avail;
        int         pend;
        bit         err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          rv;
        logic [4:0]  rvc;
        bit          cv;
        logic [4:0]  cvc;
        logic [15:0] ccyc;
        logic [15:0] icyc;
        bit          eg;
        logic [3:0]  ea;
        int          ep;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input string nm, input bit rv, input logic [4:0] rvc,
                         input bit cv, input logic [4:0] cvc, input logic [15:0] ccyc,
                         input logic [15:0] icyc, input bit eg, input logic [3:0] ea,
                         input int ep, input bit ee);
        exp_t e;
        req_valid = rv;
        req_vc    = rvc;
        cr_in     = {cv, cvc, ccyc};
        in_cycle  = icyc;
        #1;
        chk({nm, ".grant"}, int'(grant), int'(eg));
        sb.push_back('{nm, ea, ep, ee});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.nm, ".avail"}, int'(avail), int'(e.avail));
        chk({e.nm, ".pend"}, int'(pend_count), e.pend);
        chk({e.nm, ".err"}, int'(err), int'(e.err));
        req_valid = 1'b0;
        cr_in     = '0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input string nm);
        #3;
        rst_n = 1'b0;
        #1;
        chk({nm, ".avail"}, int'(avail), 15);
        chk({nm, ".pend"}, int'(pend_count), 0);
        chk({nm, ".err"}, int'(err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cr_in = '0; in_cycle = '0; req_valid = 1'b0; req_vc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.avail", int'(avail), 15);
        chk("rst.pend", int'(pend_count), 0);
        chk("rst.err", int'(err), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tbl.push_back('{1, 2, 0, 0, 0, 0, 1, 4'hF, 0});
        for (int i = 0; i < 8; i++) tbl.push_back('{1, 1, 0, 0, 0, 0, 1, (i == 7) ? 4'hD : 4'hF, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 4'hD, 0});
        tbl.push_back('{0, 0, 1, 1, 20, 10, 0, 4'hD, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 15, 0, 4'hD, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 19, 0, 4'hD, 1});
        tbl.push_back('{1, 1, 0, 0, 0, 20, 0, 4'hF, 0});
        tbl.push_back('{1, 5, 0, 0, 0, 20, 0, 4'hF, 0});
        for (int i = 0; i < tbl.size(); i++)
            apply($sformatf("vec%0d", i), tbl[i].rv, tbl[i].rvc, tbl[i].cv, tbl[i].cvc,
                  tbl[i].ccyc, tbl[i].icyc, tbl[i].eg, tbl[i].ea, tbl[i].ep, 1'b0);

        apply("hb_take0", 1, 0, 0, 0, 0, 10, 1, 4'hF, 0, 0);
        for (int i = 0; i < 8; i++)
            apply("hb_drain3", 1, 3, 0, 0, 0, 10, 1, (i == 7) ? 4'h7 : 4'hF, 0, 0);
        apply("hb_cap0", 0, 0, 1, 0, 50, 10, 0, 4'h7, 1, 0);
        apply("hb_cap3", 0, 0, 1, 3, 5, 10, 0, 4'h7, 2, 0);
        apply("hb_wait", 0, 0, 0, 0, 0, 49, 0, 4'h7, 2, 0);
        apply("hb_rel0", 0, 0, 0, 0, 0, 50, 0, 4'h7, 1, 0);
        apply("hb_rel3", 0, 0, 0, 0, 0, 51, 0, 4'hF, 0, 0);

        apply("wr_cap", 0, 0, 1, 3, 16'h0002, 16'hFFFE, 0, 4'hF, 1, 0);
        apply("wr_ffff", 0, 0, 0, 0, 0, 16'hFFFF, 0, 4'hF, 1, 0);
        apply("wr_0001", 0, 0, 0, 0, 0, 16'h0001, 0, 4'hF, 1, 0);
        apply("wr_0002", 0, 0, 0, 0, 0, 16'h0002, 0, 4'hF, 0, 0);

        for (int i = 0; i < 5; i++) apply("se_take0", 1, 0, 0, 0, 0, 100, 1, 4'hF, 0, 0);
        apply("se_cap", 0, 0, 1, 0, 100, 100, 0, 4'hF, 1, 0);
        apply("se_both", 1, 0, 0, 0, 0, 100, 1, 4'hF, 0, 0);
        for (int i = 0; i < 3; i++)
            apply("se_drain", 1, 0, 0, 0, 0, 100, 1, (i == 2) ? 4'hE : 4'hF, 0, 0);
        apply("se_empty", 1, 0, 0, 0, 0, 100, 0, 4'hE, 0, 0);

        apply("cr_cap1", 0, 0, 1, 0, 200, 200, 0, 4'hE, 1, 0);
        apply("cr_both", 0, 0, 1, 0, 300, 200, 0, 4'hF, 1, 0);
        apply("cr_hold", 0, 0, 0, 0, 0, 299, 0, 4'hF, 1, 0);
        apply("cr_rel", 0, 0, 0, 0, 0, 300, 0, 4'hF, 0, 0);

        apply("bv_cap", 0, 0, 1, 5, 300, 300, 0, 4'hF, 1, 0);
        apply("bv_rel", 0, 0, 0, 0, 0, 300, 0, 4'hF, 0, E);
        apply("bv_vc1", 1, 1, 0, 0, 0, 300, 1, 4'hD, 0, E);

        do_reset("rst_a");
        apply("ov_cap", 0, 0, 1, 2, 400, 400, 0, 4'hF, 1, 0);
        apply("ov_rel", 0, 0, 0, 0, 0, 400, 0, 4'hF, 0, E);
        for (int i = 0; i < 8; i++)
            apply("ov_drain", 1, 2, 0, 0, 0, 400, 1, (i == 7) ? 4'hB : 4'hF, 0, E);
        apply("ov_empty", 1, 2, 0, 0, 0, 400, 0, 4'hB, 0, E);

        do_reset("rst_b");
        for (int i = 0; i < 17; i++)
            apply($sformatf("qf_cap%0d", i), 0, 0, 1, 0, 1500, 500, 0, 4'hF,
                  (i < 16) ? i + 1 : 16, (i == 16) ? E : 1'b0);
        do_reset("rst_c");
        apply("post_rst", 1, 0, 0, 0, 0, 500, 1, 4'hF, 0, 0);
        apply("post_idle", 0, 0, 0, 0, 0, 1500, 0, 4'hF, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vc_credit_tracker.md
# vc_credit_tracker

Upstream-side credit receiver for the router's delayed credit-return path. Captures 22-bit credit words emitted by a downstream router's credit staging output and holds each one until its release cycle. It then returns it to a per-VC credit counter. The injector or output stage consults `grant` before sending a flit on a VC. It sits on every router output port and at each injection point, paired with the downstream router's input buffers.

## Interface
- `NUM_VCS`, default 4: virtual channels tracked, 1..32.
- `BUF_DEPTH`, default 8: downstream buffer slots per VC; also the counter reset value.
- `CRQ_DEPTH`, default 16: pending-credit queue entries; power of two.
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cr_in`  in  22  credit word: [21] valid, [20:16] vc, [15:0] release cycle.
- `in_cycle`  in  16  current simulation cycle.
- `req_valid`  in  1  sender wants to send a flit this cycle.
- `req_vc`  in  5  VC of the requested flit.
- `grant`  out  1  combinational: `req_valid` and count[`req_vc`] != 0 and `req_vc` < `NUM_VCS`.
- `avail`  out  NUM_VCS  registered; bit v = count[v] != 0.
- `pend_count`  out  clog2(CRQ_DEPTH)+1  registered pending-queue occupancy.
- `err`  out  1  sticky protocol-error flag; see Configuration.

## Operation
- Counters: one per VC, width clog2(BUF_DEPTH+1).
- Consume: on a posedge with `grant`=1, count[`req_vc`] decrements by 1. A request with count 0 is not granted and changes no state.
- Capture: on a posedge with `cr_in[21]`=1 and the queue not full, the word is written at the tail.
- Full queue: the word is dropped and the error condition is raised. Credits are never back-pressured.
- Release: at most one per cycle, head only (in order).
  - The head is due when (`in_cycle` - head.cycle) mod 2^16 < 2^15. This comparison is wrap-safe.
  - If the head is due, it is popped and count[head.vc] increments by 1 on the same edge.
  - A non-due head blocks all later entries.
- Same-edge events:
  - Capture and release together: occupancy is unchanged.
  - Increment and decrement on the same VC: net zero, and `avail` is unchanged.
  - A word captured on edge k is not eligible for release before edge k+1.
- Bad VC: a credit whose vc is >= `NUM_VCS` is discarded at release and raises the error condition.
- Overflow: a credit that would take a count above `BUF_DEPTH` saturates at `BUF_DEPTH` and raises the error condition.
- Reset (any time, including mid-operation):
  - all counters = `BUF_DEPTH`, `avail` = all ones;
  - queue empty, head = tail = 0, `pend_count` = 0;
  - `err` = 0;
  - any in-flight credits are discarded.

## Timing
- `grant` has zero latency from `req_valid`/`req_vc`. It reflects counts as of the last edge and does not see a same-cycle release.
- Credit capture to counter increment: minimum 1 cycle. The counter is updated on edge k+1 when the release cycle is <= `in_cycle` at that edge.
- `avail` and `pend_count` reflect the state after the current edge's updates.
- Pointer arithmetic:
  - head and tail are clog2(CRQ_DEPTH) bits and wrap modulo CRQ_DEPTH;
  - an occupancy counter distinguishes full from empty, so all CRQ_DEPTH entries are usable.
- No internal state machine beyond the queue and counters; the block is always ready and has no idle/busy phases.

## Configuration
- `VC_CREDIT_CHECK_EN` defined:
  - overflow, bad-VC and queue-full events set `err`, which stays 1 until reset;
  - saturation, discard and drop behaviour as specified above.
- Undefined:
  - `err` is tied to 0 and the detection logic is omitted;
  - saturation, discard and drop still apply.

## Test plan
- Reset then idle:
  - all `avail`=1 with NUM_VCS=4;
  - `pend_count`=0, `err`=0;
  - a request on VC 2 gives `grant`=1.
- Drain VC 1: 8 consecutive granted requests on VC 1 -> count 0, `avail[1]`=0, 9th request `grant`=0. Then a credit {1,1,cycle=20} captured at `in_cycle`=10 -> no increment until the edge where `in_cycle`=20, then `avail[1]`=1.
- Head blocking:
  - queue {vc0, cycle 50} then {vc3, cycle 5} at `in_cycle`=10;
  - the vc3 credit is not applied until cycle 50;
  - both apply on consecutive edges, first at `in_cycle`=50, then the next edge.
- Wrap: a credit with cycle 0x0002 captured at `in_cycle`=0xFFFE -> not released at 0xFFFF, released at 0x0002.
- Same-edge: VC 0 count 3, due credit on vc 0 and granted request on vc 0 at one edge -> count stays 3. Separately, capture plus release on one edge -> `pend_count` unchanged.
- Errors (with `VC_CREDIT_CHECK_EN`):
  - a credit to a full VC -> count stays 8, `err`=1;
  - 17 captures with no release at CRQ_DEPTH=16 -> `pend_count`=16, `err`=1;
  - asserting `rst_n`=0 mid-stream clears everything asynchronously.
